bp_cce_mem_cmd_buffer: RTL

//   Outbound buffer between the CCE message unit's mem_cmd port and the memory network.
//   - Accepts commands by ready&valid and holds them in an els_p-entry circular FIFO.
//   - Issues them downstream by ready&valid.
//   - Bounds in-flight memory commands with an outstanding counter: +1 per issued

---
 rtl/bp_cce_mem_cmd_buffer_if.sv | 34 +++
 rtl/bp_cce_mem_cmd_buffer.sv | 88 ++++++++
 2 files changed

// File: rtl/bp_cce_mem_cmd_buffer_if.sv
// Handshake bundle between the CCE mem_cmd producer, the outbound buffer and the memory network.
// The buffer side uses the slave modport; the environment side uses the master modport.
interface bp_cce_mem_cmd_buffer_if #(
   parameter int unsigned msg_width_p       = 64,
   parameter int unsigned els_p             = 2,
   parameter int unsigned max_outstanding_p = 8
);
   localparam int unsigned cnt_w = $clog2(max_outstanding_p + 1);
   localparam int unsigned occ_w = $clog2(els_p + 1);

   logic [msg_width_p-1:0] mem_cmd_i;
   logic                   mem_cmd_v_i;
   logic                   mem_cmd_ready_o;
   logic [msg_width_p-1:0] mem_cmd_o;
   logic                   mem_cmd_v_o;
   logic                   mem_cmd_ready_i;
   logic                   mem_resp_ack_i;
   logic [cnt_w-1:0]       outstanding_o;
   logic [occ_w-1:0]       occupancy_o;
   logic                   idle_o;
   logic                   error_o;

   modport slave (
      input  mem_cmd_i, mem_cmd_v_i, mem_cmd_ready_i, mem_resp_ack_i,
      output mem_cmd_ready_o, mem_cmd_o, mem_cmd_v_o, outstanding_o, occupancy_o,
             idle_o, error_o
   );

   modport master (
      output mem_cmd_i, mem_cmd_v_i, mem_cmd_ready_i, mem_resp_ack_i,
      input  mem_cmd_ready_o, mem_cmd_o, mem_cmd_v_o, outstanding_o, occupancy_o,
             idle_o, error_o
   );
endinterface

// File: rtl/bp_cce_mem_cmd_buffer.sv
// Circular FIFO for outbound memory commands, with a credit counter bounding in-flight
// commands and an idle indication used by the CCE as a memory fence.
module bp_cce_mem_cmd_buffer #(
   parameter int unsigned msg_width_p       = 64,
   parameter int unsigned els_p             = 2,
   parameter int unsigned max_outstanding_p = 8
) (
   input logic                    clk_i,
   input logic                    reset_i,
   bp_cce_mem_cmd_buffer_if.slave bus
);
   localparam int unsigned cnt_w = $clog2(max_outstanding_p + 1);
   localparam int unsigned ptr_w = $clog2(els_p);
   localparam int unsigned occ_w = $clog2(els_p + 1);

   logic [msg_width_p-1:0] mem_q [els_p];
   logic [ptr_w-1:0]       wptr_q, wptr_n;
   logic [ptr_w-1:0]       rptr_q, rptr_n;
   logic [occ_w-1:0]       occ_q, occ_n;
   logic [cnt_w-1:0]       out_q, out_n;
   logic                   err_q, err_n;
   logic                   ready, valid, enq, deq;

   // Handshakes depend only on registered state: no ack->valid or deq->ready paths.
   assign ready = (occ_q < occ_w'(els_p));
   assign valid = (occ_q != '0) && (out_q < cnt_w'(max_outstanding_p));
   assign enq   = bus.mem_cmd_v_i & ready;
   assign deq   = valid & bus.mem_cmd_ready_i;

   always_comb begin
      wptr_n = wptr_q;
      rptr_n = rptr_q;
      occ_n  = occ_q;
      out_n  = out_q;
      err_n  = err_q;

      if (enq) wptr_n = (wptr_q == ptr_w'(els_p - 1)) ? '0 : wptr_q + ptr_w'(1);
      if (deq) rptr_n = (rptr_q == ptr_w'(els_p - 1)) ? '0 : rptr_q + ptr_w'(1);

      case ({enq, deq})
         2'b10:   occ_n = occ_q + occ_w'(1);
         2'b01:   occ_n = occ_q - occ_w'(1);
         default: occ_n = occ_q;
      endcase

      // An ack with nothing in flight and no same-cycle issue is a protocol error.
      case ({deq, bus.mem_resp_ack_i})
         2'b10: out_n = out_q + cnt_w'(1);
         2'b01: begin
            if (out_q == '0) err_n = 1'b1;
            else             out_n = out_q - cnt_w'(1);
         end
         default: out_n = out_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         occ_q  <= '0;
         out_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_n;
         rptr_q <= rptr_n;
         occ_q  <= occ_n;
         out_q  <= out_n;
         err_q  <= err_n;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int unsigned i = 0; i < els_p; i++) mem_q[i] <= '0;
      end else if (enq) begin
         mem_q[wptr_q] <= bus.mem_cmd_i;
      end
   end

   assign bus.mem_cmd_ready_o = ready;
   assign bus.mem_cmd_v_o     = valid;
   assign bus.mem_cmd_o       = mem_q[rptr_q];
   assign bus.outstanding_o   = out_q;
   assign bus.occupancy_o     = occ_q;
   assign bus.idle_o          = (occ_q == '0) && (out_q == '0);
   assign bus.error_o         = err_q;
endmodule
